// File: rtl/aes_subshift_engine.sv
// -----------------------------------------------------------------------------
// aes_subshift_engine
//   Sequential AES SubBytes+ShiftRows stage. A 128-bit state is accepted over a
//   valid/ready handshake and substituted LANES bytes per clock. The encrypt
//   path uses the S-box and ShiftRows. The decrypt path uses the inverse S-box
//   and InvShiftRows. The (Inv)ShiftRows permutation is applied on the edge
//   that substitutes the last group of bytes. The result is then held until
//   downstream takes it.
//
// Parameters
//   LANES      S-box lanes per cycle (1,2,4,8,16); NCYC = 16/LANES cycles/block
//
// Ports
//   clk        system clock, rising edge
//   reset      synchronous, active-high reset
//   in_valid   input state valid
//   in_ready   engine can accept a state (IDLE only)
//   in_mode    0 = encrypt, 1 = decrypt; sampled at accept
//   in_data    AES state, byte0 = [127:120], s[r][c] = byte r+4c
//   out_valid  out_data holds a finished result
//   out_ready  downstream accepts result
//   out_data   transformed state, same byte ordering as in_data
//   busy       high while substituting or holding a result
// -----------------------------------------------------------------------------
module aes_subshift_engine #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_mode,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  localparam int NCYC = 16 / LANES;
  localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;
  localparam logic [CW-1:0] LAST_CTR = CW'(NCYC - 1);

  typedef enum logic [1:0] {
    IDLE,
    SUB,
    HOLD
  } stateT;

  stateT          state;
  stateT          stateNext;
  logic [127:0]   workReg;
  logic [127:0]   subState;
  logic [127:0]   finalState;
  logic           modeReg;
  logic [CW-1:0]  ctr;
  logic           lastStep;
  int unsigned    laneIdx;
  logic [7:0]     laneByte;

  // ---------------------------------------------------------------------------
  // GF(2^8) arithmetic, reduction polynomial x^8+x^4+x^3+x+1
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
  endfunction

  function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = '0;
    aa = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 by square-and-multiply; maps 0 to 0,
  // which is exactly what the S-box definition needs.
  function automatic logic [7:0] gfInv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] p;
    logic [7:0] e;
    r = 8'h01;
    p = a;
    e = 8'hFE;
    for (int unsigned i = 0; i < 8; i++) begin
      if (e[i]) r = gfMul(r, p);
      p = gfMul(p, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int unsigned n);
    logic [15:0] d;
    d = {x, x} << n;
    return d[15:8];
  endfunction

  // FIPS-197 S-box: inverse followed by the affine transform (constant 0x63).
  // Synthesis reduces these pure functions of one byte to 256-entry tables.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] v;
    v = gfInv(x);
    return v ^ rotl8(v, 1) ^ rotl8(v, 2) ^ rotl8(v, 3) ^ rotl8(v, 4) ^ 8'h63;
  endfunction

  // Inverse S-box: inverse affine transform (constant 0x05) then GF inverse.
  function automatic logic [7:0] invSbox(input logic [7:0] x);
    return gfInv(rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05);
  endfunction

  // ShiftRows / InvShiftRows over the column-major byte layout.
  function automatic logic [127:0] shiftRows(input logic [127:0] s, input logic inv);
    logic [127:0] r;
    int unsigned  src;
    r = '0;
    for (int unsigned row = 0; row < 4; row++) begin
      for (int unsigned col = 0; col < 4; col++) begin
        src = inv ? ((col + 4 - row) % 4) : ((col + row) % 4);
        r[127 - 8 * (row + 4 * col) -: 8] = s[127 - 8 * (row + 4 * src) -: 8];
      end
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Substitution lanes: bytes ctr*LANES .. ctr*LANES+LANES-1 of the work reg
  // ---------------------------------------------------------------------------
  always_comb begin
    subState = workReg;
    laneIdx  = 0;
    laneByte = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      laneIdx  = 32'(ctr) * LANES + l;
      laneByte = workReg[127 - 8 * laneIdx -: 8];
      subState[127 - 8 * laneIdx -: 8] = modeReg ? invSbox(laneByte) : sbox(laneByte);
    end
  end

  assign finalState = shiftRows(subState, modeReg);
  assign lastStep   = (state == SUB) && (ctr == LAST_CTR);

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) stateNext = SUB;
      end
      SUB: begin
        busy = 1'b1;
        if (ctr == LAST_CTR) stateNext = HOLD;
      end
      HOLD: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      workReg  <= '0;
      modeReg  <= 1'b0;
      ctr      <= '0;
      out_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            workReg <= in_data;
            modeReg <= in_mode;
            ctr     <= '0;
          end
        end
        SUB: begin
          workReg <= subState;
          if (lastStep) begin
            out_data <= finalState;
            ctr      <= '0;
          end else begin
            ctr <= ctr + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
